// File: rtl/vga_register_bank_display.sv
// Overlay block that draws CHANNELS registers as rows of WIDTH squares, MSB leftmost.
// Data is snapshotted once per frame in blanking; recently changed bits are highlighted.
module vga_register_bank_display #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned START_H     = 10,
    parameter int unsigned START_V     = 380,
    parameter int unsigned SQ          = 5,
    parameter int unsigned PITCH_H     = 10,
    parameter int unsigned PITCH_V     = 8,
    parameter int unsigned SNAP_V      = 490,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter logic [2:0]  ON_COL      = 3'b100,
    parameter logic [2:0]  CHG_ON_COL  = 3'b010,
    parameter logic [2:0]  CHG_OFF_COL = 3'b001
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*WIDTH-1:0]    data_in,
    input  logic                         freeze,
    input  logic [10:0]                  vga_h,
    input  logic [10:0]                  vga_v,
    input  logic [2:0]                   bg,
    output logic [2:0]                   pixel_out,
    output logic                         display_on
);

    localparam int unsigned VW    = 11;
    localparam int unsigned NB    = CHANNELS * WIDTH;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

    localparam logic [VW-1:0]    H_LO    = VW'(START_H);
    localparam logic [VW-1:0]    H_HI    = VW'(START_H + WIDTH * PITCH_H);
    localparam logic [VW-1:0]    V_LO    = VW'(START_V);
    localparam logic [VW-1:0]    V_HI    = VW'(START_V + CHANNELS * PITCH_V);
    localparam logic [VW-1:0]    SNAP_L  = VW'(SNAP_V);
    localparam logic [VW-1:0]    HX_LAST = VW'(PITCH_H - 1);
    localparam logic [VW-1:0]    VY_LAST = VW'(PITCH_V - 1);
    localparam logic [VW-1:0]    SQ_L    = VW'(SQ);
    localparam logic [CNT_W-1:0] HOLD    = CNT_W'(HOLD_FRAMES);

    logic [VW-1:0]                   r_hx, r_hcol, r_vy, r_vrow;
    logic [VW-1:0]                   w_hx, w_hcol, w_vy, w_vrow;
    logic [NB-1:0]                   r_snap, r_chg, w_diff;
    logic [CHANNELS-1:0][CNT_W-1:0]  r_cnt;
    logic                            r_primed;
    logic [2:0]                      r_pix, w_pix;
    logic                            r_disp;
    logic                            w_in_area, w_in_sq, w_sample, w_bit, w_bit_chg;
    logic [IDX_W-1:0]                w_idx;

    // Running column/offset counters; restart at the block's first column.
    always_comb begin
        w_hx   = r_hx + VW'(1);
        w_hcol = r_hcol;
        if (vga_h == H_LO) begin
            w_hx   = '0;
            w_hcol = '0;
        end else if (r_hx == HX_LAST) begin
            w_hx   = '0;
            w_hcol = r_hcol + VW'(1);
        end
    end

    // Row/line counters advance once per line, at column 0.
    always_comb begin
        w_vy   = r_vy;
        w_vrow = r_vrow;
        if (vga_h == '0) begin
            if (vga_v == V_LO) begin
                w_vy   = '0;
                w_vrow = '0;
            end else if (r_vy == VY_LAST) begin
                w_vy   = '0;
                w_vrow = r_vrow + VW'(1);
            end else begin
                w_vy   = r_vy + VW'(1);
            end
        end
    end

    always_comb begin
        w_in_area = (vga_h >= H_LO) && (vga_h < H_HI) && (vga_v >= V_LO) && (vga_v < V_HI);
        w_in_sq   = (w_hx < SQ_L) && (w_vy < SQ_L);
        w_sample  = (vga_v == SNAP_L) && (vga_h == '0) && !freeze;
        w_diff    = data_in ^ r_snap;
        w_idx     = IDX_W'(int'(w_vrow) * WIDTH + (WIDTH - 1) - int'(w_hcol));
        w_bit     = r_snap[w_idx];
        w_bit_chg = r_chg[w_idx];
        w_pix     = bg;
        if (w_in_area && w_in_sq) begin
            if (w_bit_chg && w_bit)  w_pix = CHG_ON_COL;
            else if (w_bit_chg)      w_pix = CHG_OFF_COL;
            else if (w_bit)          w_pix = ON_COL;
            else                     w_pix = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hx   <= '0;
            r_hcol <= '0;
            r_vy   <= '0;
            r_vrow <= '0;
            r_pix  <= '0;
            r_disp <= 1'b0;
        end else begin
            r_hx   <= w_hx;
            r_hcol <= w_hcol;
            r_vy   <= w_vy;
            r_vrow <= w_vrow;
            r_pix  <= w_pix;
            r_disp <= w_in_area;
        end
    end

    // Frame snapshot and per-channel highlight hold; a new change replaces the old mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap   <= '0;
            r_chg    <= '0;
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else if (w_sample) begin
            r_snap   <= data_in;
            r_primed <= 1'b1;
            for (int c = 0; c < CHANNELS; c++) begin
                if (HOLD_FRAMES != 0 && r_primed && w_diff[c*WIDTH +: WIDTH] != '0) begin
                    r_chg[c*WIDTH +: WIDTH] <= w_diff[c*WIDTH +: WIDTH];
                    r_cnt[c]                <= HOLD;
                end else if (r_cnt[c] > CNT_W'(1)) begin
                    r_cnt[c] <= r_cnt[c] - CNT_W'(1);
                end else if (r_cnt[c] == CNT_W'(1)) begin
                    r_cnt[c]                <= '0;
                    r_chg[c*WIDTH +: WIDTH] <= '0;
                end
            end
        end
    end

    assign pixel_out  = r_pix;
    assign display_on = r_disp;

endmodule

// File: tb/tb_vga_register_bank_display.sv
// Directed bench for vga_register_bank_display using a compressed raster:
// only the sample line and the lines/columns under inspection are visited.
module tb_vga_register_bank_display;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int START_H  = 10;
    localparam int START_V  = 380;
    localparam int SQ       = 5;
    localparam int PITCH_H  = 10;
    localparam int PITCH_V  = 8;
    localparam int SNAP_V   = 490;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic                      freeze;
    logic [10:0]               vga_h, vga_v;
    logic [2:0]                bg;
    logic [2:0]                pixel_out;
    logic                      display_on;

    int n_cmp = 0;
    int n_err = 0;

    vga_register_bank_display dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .freeze     (freeze),
        .vga_h      (vga_h),
        .vga_v      (vga_v),
        .bg         (bg),
        .pixel_out  (pixel_out),
        .display_on (display_on)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] colour(input logic on, input logic ch);
        if (ch && on) return 3'b010;
        if (ch)       return 3'b001;
        if (on)       return 3'b100;
        return 3'b000;
    endfunction

    // Present one (h,v) and sample the registered result after the edge.
    task automatic step(input int h, input int v);
        vga_h = 11'(h);
        vga_v = 11'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic sample_frame();
        step(0, SNAP_V);
    endtask

    task automatic walk_lines(input int v_from, input int v_to);
        for (int v = v_from; v <= v_to; v++) step(0, v);
    endtask

    task automatic scan_line(input int v, input logic [7:0] on, input logic [7:0] chg,
                             input string tag);
        int yy;
        yy = (v - START_V) % PITCH_V;
        step(0, v);
        step(START_H - 1, v);
        chk({tag, "_left_on"}, 3'(display_on), 3'b000);
        chk({tag, "_left_px"}, pixel_out, bg);
        for (int h = 0; h < WIDTH * PITCH_H; h++) begin
            int b;
            logic [2:0] e;
            step(START_H + h, v);
            b = WIDTH - 1 - h / PITCH_H;
            e = ((h % PITCH_H) < SQ && yy < SQ) ? colour(on[b], chg[b]) : bg;
            chk($sformatf("%s_h%0d_px", tag, h), pixel_out, e);
            chk($sformatf("%s_h%0d_on", tag, h), 3'(display_on), 3'b001);
        end
        step(START_H + WIDTH * PITCH_H, v);
        chk({tag, "_right_on"}, 3'(display_on), 3'b000);
        chk({tag, "_right_px"}, pixel_out, bg);
    endtask

    task automatic check_row(input int row, input logic [7:0] on, input logic [7:0] chg,
                             input string tag);
        if (row > 0) walk_lines(START_V, START_V + row * PITCH_V - 1);
        scan_line(START_V + row * PITCH_V, on, chg, tag);
    endtask

    initial begin
        reset   = 1'b1;
        freeze  = 1'b0;
        bg      = 3'b110;
        data_in = {8'h00, 8'hFF, 8'h00, 8'hA5};
        vga_h   = 11'(START_H);
        vga_v   = 11'(START_V);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_px", pixel_out, 3'b000);
        chk("reset_on", 3'(display_on), 3'b000);
        reset = 1'b0;

        check_row(0, 8'h00, 8'h00, "pre_sample_r0");

        // First sample primes, second confirms steady display without highlight
        sample_frame();
        sample_frame();
        check_row(0, 8'hA5, 8'h00, "t1_r0");
        check_row(1, 8'h00, 8'h00, "t1_r1");
        check_row(2, 8'hFF, 8'h00, "t1_r2");

        data_in[15:8]  = 8'h81;
        data_in[23:16] = 8'h7F;
        sample_frame();
        check_row(1, 8'h81, 8'h81, "t2_first");
        check_row(2, 8'h7F, 8'h80, "t3_first");

        repeat (10) sample_frame();
        freeze        = 1'b1;
        data_in[7:0]  = 8'h00;
        repeat (5) sample_frame();
        check_row(0, 8'hA5, 8'h00, "t5_frozen_r0");
        check_row(1, 8'h81, 8'h81, "t5_frozen_r1");
        freeze        = 1'b0;
        data_in[7:0]  = 8'hA5;

        repeat (19) sample_frame();
        check_row(1, 8'h81, 8'h81, "t2_last");
        check_row(2, 8'h7F, 8'h80, "t3_last");
        sample_frame();
        check_row(1, 8'h81, 8'h00, "t2_after");
        check_row(2, 8'h7F, 8'h00, "t3_after");

        // Mid-frame data change must stay invisible until the next snapshot
        walk_lines(START_V, 399);
        data_in[31:24] = 8'hFF;
        scan_line(400, 8'h7F, 8'h00, "t4_mid_r2");
        walk_lines(401, 403);
        scan_line(404, 8'h00, 8'h00, "t4_old_r3");
        sample_frame();
        check_row(3, 8'hFF, 8'hFF, "t4_new_r3");

        walk_lines(START_V, 384);
        scan_line(385, 8'hA5, 8'h00, "gap_line");

        step(START_H + 5, START_V + CHANNELS * PITCH_V);
        chk("below_on", 3'(display_on), 3'b000);
        chk("below_px", pixel_out, bg);
        step(START_H + 5, START_V - 1);
        chk("above_on", 3'(display_on), 3'b000);
        chk("above_px", pixel_out, bg);

        // Asynchronous reset in the middle of the block
        walk_lines(START_V, 382);
        step(START_H, 382);
        step(START_H + 1, 382);
        chk("t6_pre_px", pixel_out, 3'b100);
        reset = 1'b1;
        #1;
        chk("t6_async_px", pixel_out, 3'b000);
        chk("t6_async_on", 3'(display_on), 3'b000);
        step(START_H + 2, 382);
        chk("t6_held_px", pixel_out, 3'b000);
        reset = 1'b0;
        step(START_H - 1, START_V);
        chk("t6_lbound_on", 3'(display_on), 3'b000);
        chk("t6_lbound_px", pixel_out, bg);
        step(START_H + WIDTH * PITCH_H, START_V);
        chk("t6_rbound_on", 3'(display_on), 3'b000);
        chk("t6_rbound_px", pixel_out, bg);
        check_row(0, 8'h00, 8'h00, "t6_cleared_r0");

        sample_frame();
        check_row(0, 8'hA5, 8'h00, "t6_prime_r0");
        data_in[7:0] = 8'h3C;
        sample_frame();
        check_row(0, 8'h3C, 8'h99, "t6_primed_chg_r0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
